// File: rtl/dfr_run_sequencer.sv
// dfr_run_sequencer: runs init/train/test reservoir phases (start/abort in; busy/phase/done/err out; sample fetch, step req/ack, output write)
module dfr_run_sequencer #(
  parameter int ADDR_WIDTH = 30,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_WIDTH-1:0]  num_init_samples,
  input  logic [CNT_WIDTH-1:0]  num_train_samples,
  input  logic [CNT_WIDTH-1:0]  num_test_samples,
  input  logic [CNT_WIDTH-1:0]  num_steps_per_sample,
  output logic                  busy,
  output logic [1:0]            phase,
  output logic                  done,
  output logic                  err,
  output logic                  sample_rd_en,
  output logic [ADDR_WIDTH-1:0] sample_addr,
  output logic                  load_sample,
  output logic                  step_req,
  input  logic                  step_ack,
  output logic                  out_wen,
  output logic [ADDR_WIDTH-1:0] out_addr
);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, STEP, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] phase_q, phase_d, first_phase, next_phase;
  logic [CNT_WIDTH-1:0] n_init_q, n_init_d, n_train_q, n_train_d, n_test_q, n_test_d, n_steps_q, n_steps_d;
  logic [CNT_WIDTH-1:0] step_cnt_q, step_cnt_d, samp_cnt_q, samp_cnt_d, phase_cnt;
  logic [ADDR_WIDTH-1:0] sample_addr_q, sample_addr_d, out_addr_q, out_addr_d;
  logic err_q, err_d, start_ok, ack, step_last, samp_last;
  always_comb begin
    start_ok = num_steps_per_sample != '0 && (num_init_samples | num_train_samples | num_test_samples) != '0;
    first_phase = num_init_samples != '0 ? 2'd1 : num_train_samples != '0 ? 2'd2 : 2'd3;
    ack = state_q == STEP && step_ack && !abort;
    phase_cnt = phase_q == 2'd1 ? n_init_q : phase_q == 2'd2 ? n_train_q : n_test_q;
    step_last = step_cnt_q == n_steps_q - CNT_WIDTH'(1);
    samp_last = samp_cnt_q == phase_cnt - CNT_WIDTH'(1);
    next_phase = phase_q == 2'd1 && n_train_q != '0 ? 2'd2 : phase_q != 2'd3 && n_test_q != '0 ? 2'd3 : 2'd0;
  end
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start && start_ok ? FETCH : IDLE;
      FETCH:   state_d = LOAD;
      LOAD:    state_d = STEP;
      STEP:    state_d = ack && step_last ? (samp_last && next_phase == 2'd0 ? DONE : FETCH) : STEP;
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) state_d = IDLE;
  end
  always_comb begin
    busy = state_q != IDLE;
    done = state_q == DONE;
    sample_rd_en = state_q == FETCH;
    load_sample = state_q == LOAD;
    step_req = state_q == STEP;
    out_wen = ack && phase_q[1];
    phase = phase_q;
    err = err_q;
    sample_addr = sample_addr_q;
    out_addr = out_addr_q;
  end
  always_comb begin
    phase_d = phase_q;
    n_init_d = n_init_q;
    n_train_d = n_train_q;
    n_test_d = n_test_q;
    n_steps_d = n_steps_q;
    step_cnt_d = step_cnt_q;
    samp_cnt_d = samp_cnt_q;
    sample_addr_d = sample_addr_q;
    out_addr_d = out_addr_q;
    err_d = 1'b0;
    if (state_q == IDLE) begin
      err_d = start && !start_ok;
      if (start && start_ok) begin
        n_init_d = num_init_samples;
        n_train_d = num_train_samples;
        n_test_d = num_test_samples;
        n_steps_d = num_steps_per_sample;
        phase_d = first_phase;
        step_cnt_d = '0;
        samp_cnt_d = '0;
        sample_addr_d = '0;
        out_addr_d = '0;
      end
    end else if (abort) phase_d = 2'd0;
    else if (ack) begin
      out_addr_d = phase_q[1] ? out_addr_q + ADDR_WIDTH'(1) : out_addr_q;
      step_cnt_d = step_last ? '0 : step_cnt_q + CNT_WIDTH'(1);
      if (step_last) begin
        sample_addr_d = sample_addr_q + ADDR_WIDTH'(1);
        samp_cnt_d = samp_last ? '0 : samp_cnt_q + CNT_WIDTH'(1);
        phase_d = samp_last ? next_phase : phase_q;
      end
    end
  end
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      phase_q <= '0;
      n_init_q <= '0;
      n_train_q <= '0;
      n_test_q <= '0;
      n_steps_q <= '0;
      step_cnt_q <= '0;
      samp_cnt_q <= '0;
      sample_addr_q <= '0;
      out_addr_q <= '0;
      err_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      n_init_q <= n_init_d;
      n_train_q <= n_train_d;
      n_test_q <= n_test_d;
      n_steps_q <= n_steps_d;
      step_cnt_q <= step_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      sample_addr_q <= sample_addr_d;
      out_addr_q <= out_addr_d;
      err_q <= err_d;
    end
endmodule

// File: tb/tb_dfr_run_sequencer.sv
// tb_dfr_run_sequencer: directed scoreboard bench for dfr_run_sequencer
module tb_dfr_run_sequencer;
  localparam int AW = 30;
  localparam int CW = 32;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, step_ack = 0;
  logic [CW-1:0] n_init = 0, n_train = 0, n_test = 0, n_steps = 0;
  logic busy, done, err, sample_rd_en, load_sample, step_req, out_wen;
  logic [1:0] phase;
  logic [AW-1:0] sample_addr, out_addr;
  int checks = 0, errors = 0, cyc = 0, ack_mode = 0, dcnt = 0, ei;
  logic [AW+1:0] exp_rd[$], exp_wr[$], e;
  int exp_done[$], exp_err[$];
  dfr_run_sequencer #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start), .abort(abort),
    .num_init_samples(n_init), .num_train_samples(n_train), .num_test_samples(n_test),
    .num_steps_per_sample(n_steps), .busy(busy), .phase(phase), .done(done), .err(err),
    .sample_rd_en(sample_rd_en), .sample_addr(sample_addr), .load_sample(load_sample),
    .step_req(step_req), .step_ack(step_ack), .out_wen(out_wen), .out_addr(out_addr)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    if (ack_mode == 1) step_ack = 1;
    else if (ack_mode == 2) begin
      if (!step_req) begin dcnt = 0; step_ack = 0; end
      else if (dcnt == 3) begin dcnt = 0; step_ack = 1; end
      else begin dcnt++; step_ack = 0; end
    end
  end
  always @(negedge clk) if (rst_n) begin
    if (sample_rd_en) begin
      checks++;
      if (exp_rd.size() == 0) begin errors++; $display("FAIL rd unexpected phase=%0d addr=%0d", phase, sample_addr); end
      else begin
        e = exp_rd.pop_front();
        if ({phase, sample_addr} !== e) begin errors++; $display("FAIL rd got phase=%0d addr=%0d exp phase=%0d addr=%0d", phase, sample_addr, e[AW+1:AW], e[AW-1:0]); end
      end
    end
    if (out_wen) begin
      checks++;
      if (exp_wr.size() == 0) begin errors++; $display("FAIL wr unexpected phase=%0d addr=%0d", phase, out_addr); end
      else begin
        e = exp_wr.pop_front();
        if ({phase, out_addr} !== e) begin errors++; $display("FAIL wr got phase=%0d addr=%0d exp phase=%0d addr=%0d", phase, out_addr, e[AW+1:AW], e[AW-1:0]); end
      end
    end
    if (done) begin
      checks++;
      if (exp_done.size() == 0) begin errors++; $display("FAIL done unexpected cyc=%0d", cyc); end
      else begin
        ei = exp_done.pop_front();
        if (cyc != ei) begin errors++; $display("FAIL done got cyc=%0d exp cyc=%0d", cyc, ei); end
      end
    end
    if (err) begin
      checks++;
      if (exp_err.size() == 0) begin errors++; $display("FAIL err unexpected cyc=%0d", cyc); end
      else begin
        ei = exp_err.pop_front();
        if (cyc != ei) begin errors++; $display("FAIL err got cyc=%0d exp cyc=%0d", cyc, ei); end
      end
    end
  end
  function automatic logic [AW+1:0] pk(input int p, input int a);
    return {2'(p), AW'(a)};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin errors++; $display("FAIL %s got=%0h exp=%0h", name, got, exp); end
  endtask
  task automatic set_counts(input int a, input int b, input int c, input int s);
    n_init = CW'(a);
    n_train = CW'(b);
    n_test = CW'(c);
    n_steps = CW'(s);
  endtask
  task automatic pulse_start(output int c0);
    tick();
    start = 1;
    c0 = cyc;
    tick();
    start = 0;
  endtask
  task automatic wait_idle(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 200);
    chk(name, 64'(busy), 0);
  endtask
  task automatic expect_111_2(input int c0);
    exp_rd.push_back(pk(1, 0)); exp_rd.push_back(pk(2, 1)); exp_rd.push_back(pk(3, 2));
    exp_wr.push_back(pk(2, 0)); exp_wr.push_back(pk(2, 1)); exp_wr.push_back(pk(3, 2)); exp_wr.push_back(pk(3, 3));
    exp_done.push_back(c0 + 13);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    int c0, req_cyc, wait_cyc, bad_phase, n;
    #12;
    chk("reset_ctl", 64'({busy, phase, done, err, sample_rd_en, load_sample, step_req, out_wen}), 0);
    chk("reset_addr", 64'({sample_addr, out_addr}), 0);
    tick();
    rst_n = 1;
    ack_mode = 1;
    set_counts(1, 1, 1, 2);
    pulse_start(c0);
    expect_111_2(c0);
    wait_idle("t1_idle");
    ack_mode = 2;
    set_counts(0, 2, 0, 1);
    pulse_start(c0);
    exp_rd.push_back(pk(2, 0)); exp_rd.push_back(pk(2, 1));
    exp_wr.push_back(pk(2, 0)); exp_wr.push_back(pk(2, 1));
    exp_done.push_back(c0 + 13);
    req_cyc = 0; wait_cyc = 0; bad_phase = 0; n = 0;
    do begin
      @(negedge clk);
      n++;
      if (step_req) req_cyc++;
      if (step_req && !step_ack) wait_cyc++;
      if (phase != 2'd0 && phase != 2'd2) bad_phase++;
    end while (busy && n < 200);
    chk("t2_idle", 64'(busy), 0);
    chk("t2_req_cycles", 64'(req_cyc), 8);
    chk("t2_wait_cycles", 64'(wait_cyc), 6);
    chk("t2_phase", 64'(bad_phase), 0);
    ack_mode = 0;
    step_ack = 0;
    set_counts(1, 1, 1, 0);
    pulse_start(c0);
    exp_err.push_back(c0 + 1);
    repeat (3) begin @(negedge clk); chk("t3_steps0_busy", 64'(busy), 0); end
    set_counts(0, 0, 0, 1);
    pulse_start(c0);
    exp_err.push_back(c0 + 1);
    repeat (3) begin @(negedge clk); chk("t3_samples0_busy", 64'(busy), 0); end
    ack_mode = 1;
    set_counts(2, 0, 1, 1);
    pulse_start(c0);
    exp_rd.push_back(pk(1, 0)); exp_rd.push_back(pk(1, 1)); exp_rd.push_back(pk(3, 2));
    exp_wr.push_back(pk(3, 0));
    exp_done.push_back(c0 + 10);
    tick(); tick(); tick();
    set_counts(5, 5, 5, 5);
    start = 1;
    tick();
    start = 0;
    wait_idle("t4_idle");
    ack_mode = 0;
    step_ack = 0;
    set_counts(0, 2, 0, 2);
    pulse_start(c0);
    exp_rd.push_back(pk(2, 0));
    exp_wr.push_back(pk(2, 0));
    tick(); tick();
    step_ack = 1;
    tick();
    abort = 1;
    @(negedge clk);
    chk("t5_abort_wen", 64'(out_wen), 0);
    chk("t5_abort_req", 64'(step_req), 1);
    tick();
    abort = 0;
    step_ack = 0;
    @(negedge clk);
    chk("t5_after_abort", 64'({busy, phase, step_req}), 0);
    repeat (10) @(negedge clk);
    tick();
    ack_mode = 1;
    set_counts(1, 1, 1, 2);
    pulse_start(c0);
    exp_rd.push_back(pk(1, 0)); exp_rd.push_back(pk(2, 1));
    exp_wr.push_back(pk(2, 0));
    repeat (6) tick();
    @(negedge clk);
    chk("t6_req", 64'(step_req), 1);
    chk("t6_saddr", 64'(sample_addr), 1);
    #2;
    rst_n = 0;
    #1;
    chk("t6_rst_ctl", 64'({busy, phase, done, err, sample_rd_en, load_sample, step_req, out_wen}), 0);
    chk("t6_rst_addr", 64'({sample_addr, out_addr}), 0);
    tick();
    rst_n = 1;
    pulse_start(c0);
    expect_111_2(c0);
    wait_idle("t6_rerun_idle");
    repeat (3) @(negedge clk);
    chk("queues_empty", 64'(exp_rd.size() + exp_wr.size() + exp_done.size() + exp_err.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dfr_run_sequencer.md
# dfr_run_sequencer

Sequences one complete reservoir run (init, train and test phases) using the sample and step counts from the AXI configuration registers. On a `start` pulse (ctrl bit 0), it snapshots the configuration and fetches each input sample from sample memory. It then drives the reservoir one step at a time over a req/ack handshake, and writes the reservoir node output during the train and test phases. It sits between the AXI config register block (which supplies `start` and consumes `busy`) and the reservoir/memory datapath.

## Interface
- `ADDR_WIDTH`, 30, width of the sample-memory and output-memory word addresses.
- `CNT_WIDTH`, 32, width of the configuration counts and internal counters.
- `S_AXI_ACLK`  in  1  single clock; all logic runs on its rising edge.
- `S_AXI_ARESETN`  in  1  reset; asynchronous, active-low.
- `start`  in  1  one-cycle run request.
- `abort`  in  1  terminate the current run.
- `num_init_samples`, `num_train_samples`, `num_test_samples`  in  CNT_WIDTH each  samples per phase.
- `num_steps_per_sample`  in  CNT_WIDTH  reservoir steps per sample.
- `busy`  out  1  high while a run is active.
- `phase`  out  2  0 = none, 1 = init, 2 = train, 3 = test.
- `done`  out  1  one-cycle pulse when a run completes normally.
- `err`  out  1  one-cycle pulse when a `start` is rejected.
- `sample_rd_en`  out  1  sample-memory read strobe.
- `sample_addr`  out  ADDR_WIDTH  sample-memory word address.
- `load_sample`  out  1  tells the reservoir to take the sample-memory data this cycle.
- `step_req`  out  1  request one reservoir step.
- `step_ack`  in  1  the requested step has completed.
- `out_wen`  out  1  output-memory write strobe.
- `out_addr`  out  ADDR_WIDTH  output-memory word address.

## Operation
- States:
  - IDLE: waits for a run request.
  - FETCH: issues the sample read.
  - LOAD: hands the sample to the reservoir.
  - STEP: runs the reservoir steps for the current sample.
  - DONE: signals completion.
- All outputs reset to 0, the state to IDLE, and all counters to 0.
- Start acceptance (IDLE only):
  - `start` is accepted only when `num_steps_per_sample != 0` and the sum of the three sample counts is non-zero.
  - Otherwise `err` pulses, and the block stays in IDLE.
  - On acceptance, all four counts are latched. Later input changes do not affect the run.
  - `sample_addr` and `out_addr` clear to 0.
  - `phase` is set to the first phase with a non-zero sample count, and the state moves to FETCH.
- A `start` seen outside IDLE is ignored and produces no `err`.
- FETCH: `sample_rd_en` is high for 1 cycle; next state LOAD.
- LOAD: `load_sample` is high for 1 cycle, with the 1-cycle memory latency assumed met; next state STEP.
- STEP:
  - `step_req` is held high.
  - Each cycle with `step_ack` high counts one step.
  - In train and test, `out_wen` is high in the same cycle as the ack, and `out_addr` increments after the write.
  - On the ack of the last step of a sample, the sample counter increments and `sample_addr` increments.
  - The next state is then one of:
    - FETCH, if the phase has samples remaining;
    - FETCH of the next phase with a non-zero sample count, with the sample counter cleared;
    - DONE, if no phases remain.
- Phases with a zero sample count are skipped entirely.
- `sample_addr` is a single running index across all phases, so samples are stored contiguously as init, then train, then test.
- DONE: `done` is high for 1 cycle; `busy` and `phase` drop to 0; next state IDLE.
- `abort` in any state other than IDLE:
  - returns the block to IDLE on the next edge;
  - clears `busy`, `phase`, `step_req` and all strobes;
  - produces no `done` pulse, and does not issue the `out_wen` for an ack seen in the same cycle.
- `abort` in IDLE has no effect.
- `abort` takes priority over `step_ack`.
- Both addresses wrap modulo 2^ADDR_WIDTH with no flag.

## Timing
- `busy` = (state != IDLE). All outputs are registered or decoded from state, with no combinational path from `step_ack` except to `out_wen`.
- For `start` high in cycle 0:
  - FETCH is in cycle 1;
  - LOAD is in cycle 2;
  - STEP begins in cycle 3.
- With `step_ack` tied high, each sample takes 2 + S cycles, where S is the number of steps per sample.
- The step handshake supports back-to-back acks: `step_req` stays high between steps of the same sample.
- `step_req` is 0 in FETCH and LOAD.
- DONE is entered the cycle after the final ack. `done` pulses in that cycle, and IDLE follows in the next cycle.
- Total run length with `step_ack` tied high is N × (2 + S) + 1 cycles from FETCH to DONE inclusive, where N is the total number of samples.
- Reset asserted mid-run forces IDLE and all-zero outputs immediately (asynchronously). No `done` is produced.

## Test plan
- Counts init = 1, train = 1, test = 1, steps = 2, `step_ack` tied high, pulse `start`:
  - `phase` sequence is 1, 2, 3;
  - `sample_addr` takes values 0, 1, 2;
  - there are 4 `out_wen` pulses, at `out_addr` 0 to 3;
  - `done` pulses in cycle 13 after `start`.
- Counts init = 0, train = 2, test = 0, steps = 1, `step_ack` delayed 3 cycles per step:
  - `phase` stays at 2;
  - there are 2 writes;
  - `step_req` holds high through each wait;
  - there is one `done` pulse.
- `start` with steps = 0, then `start` with all sample counts 0:
  - `err` pulses each time;
  - `busy` stays 0.
- During a run, change the counts and pulse `start` again:
  - the run uses the latched counts;
  - the second `start` is ignored, with no `err`.
- `abort` in the same cycle as a `step_ack` during train:
  - there is no `out_wen`;
  - the block is in IDLE the next cycle, with no `done`.
- Deassert `S_AXI_ARESETN` mid-STEP:
  - all outputs go to 0 immediately;
  - a subsequent `start` runs normally from `sample_addr` 0.
